// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: AHB-Lite write-master bus between the boot loader and the bus matrix
interface uart_boot_loader_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HREADY, HRESP
  );
  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HREADY, HRESP
  );
endinterface

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: UART image receiver writing SRAM over AHB-Lite, releases CPU on checksum match; optional RX silence timeout under UART_BOOT_TIMEOUT_EN
module uart_boot_loader #(
  parameter int unsigned BAUD_DIV    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_WORDS   = 16384
`ifdef UART_BOOT_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 1000000
`endif
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                RXD,
  uart_boot_loader_if.master  bus,
  output logic                CPU_HOLD,
  output logic                BOOT_DONE,
  output logic                BOOT_ERR
);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [3:0] {SYNC, LEN0, LEN1, DATA, ADDR, WAIT, CSUM, DONE, ERR} st_t;
  localparam logic [15:0] HALF = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL = 16'(BAUD_DIV - 1);
  localparam logic [16:0] MAXW = 17'(MAX_WORDS);
  logic        rx_s1, rx_s2, rx_d;
  rx_t         rx_st, rx_nx;
  logic [15:0] cnt;
  logic [2:0]  bitn;
  logic [7:0]  rx_sh;
  logic        tick, byte_vld, frame_err;
  st_t         st, nx;
  logic        done_q, boot_err;
  logic [15:0] nlen, idx;
  logic [31:0] word;
  logic [1:0]  bcnt;
  logic [7:0]  csum, pend, b;
  logic        pend_vld, fault;
  logic        stall, take, tmo, err_in, fault_now;
  logic [16:0] len_in;
  // two-flop synchroniser plus one history flop for start-edge detection
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) {rx_s1, rx_s2, rx_d} <= 3'b111;
    else {rx_s1, rx_s2, rx_d} <= {RXD, rx_s1, rx_s2};
  // receiver state register
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) rx_st <= R_IDLE;
    else rx_st <= rx_nx;
  assign tick = cnt == (rx_st == R_START ? HALF : FULL);
  // receiver next state: start bit rechecked at half a bit, then one sample per bit
  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      R_IDLE:  if (rx_d && !rx_s2) rx_nx = R_START;
      R_START: if (tick) rx_nx = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (tick && bitn == 3'd7) rx_nx = R_STOP;
      default: if (tick) rx_nx = R_IDLE;
    endcase
  end
  // receiver outputs: stop bit sample decides between a good byte and a framing error
  always_comb begin
    byte_vld  = rx_st == R_STOP && tick && rx_s2;
    frame_err = rx_st == R_STOP && tick && !rx_s2;
  end
  // bit timer, data bit counter and LSB-first shift register
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      cnt   <= '0;
      bitn  <= '0;
      rx_sh <= '0;
    end else begin
      cnt <= (rx_st == R_IDLE || tick) ? 16'd0 : cnt + 16'd1;
      if (rx_st != R_DATA) bitn <= 3'd0;
      else if (tick) bitn <= bitn + 3'd1;
      if (rx_st == R_DATA && tick) rx_sh <= {rx_s2, rx_sh[7:1]};
    end
`ifdef UART_BOOT_TIMEOUT_EN
  logic [31:0] tcnt;
  // RX silence counter, frozen while idle in SYNC or finished in DONE
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) tcnt <= '0;
    else if (byte_vld || st == ERR) tcnt <= '0;
    else if (st != SYNC && st != DONE && !tmo) tcnt <= tcnt + 32'd1;
  assign tmo = tcnt >= TIMEOUT_CYC;
`else
  assign tmo = 1'b0;
`endif
  assign stall     = st == ADDR || st == WAIT;
  assign take      = !stall && st != DONE && st != ERR && (pend_vld || byte_vld);
  assign b         = pend_vld ? pend : rx_sh;
  assign err_in    = frame_err || tmo;
  assign fault_now = err_in || (byte_vld && pend_vld);
  assign len_in    = {1'b0, b, nlen[7:0]};
  // loader state register; DONE decode registered so CPU_HOLD and BOOT_DONE switch together
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      st     <= SYNC;
      done_q <= 1'b0;
    end else begin
      st     <= nx;
      done_q <= nx == DONE;
    end
  // loader next state; faults seen during a transfer are deferred to the end of its data phase
  always_comb begin
    nx = st;
    case (st)
      SYNC:    nx = err_in ? ERR : (take && b == 8'hA5) ? LEN0 : SYNC;
      LEN0:    nx = err_in ? ERR : take ? LEN1 : LEN0;
      LEN1:    nx = err_in ? ERR : !take ? LEN1 : len_in > MAXW ? ERR : len_in == 17'd0 ? CSUM : DATA;
      DATA:    nx = err_in ? ERR : (take && bcnt == 2'd3) ? ADDR : DATA;
      ADDR:    nx = WAIT;
      WAIT:    nx = !bus.HREADY ? WAIT : (bus.HRESP || fault || fault_now) ? ERR : (idx + 16'd1 == nlen) ? CSUM : DATA;
      CSUM:    nx = err_in ? ERR : !take ? CSUM : b == csum ? DONE : ERR;
      DONE:    nx = DONE;
      default: nx = SYNC;
    endcase
  end
  // loader datapath: length, word assembly, checksum, index and the one-byte overrun buffer
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      boot_err <= 1'b0;
      nlen     <= '0;
      idx      <= '0;
      word     <= '0;
      bcnt     <= '0;
      csum     <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      fault    <= 1'b0;
    end else if (st == ERR) begin
      boot_err <= 1'b1;
      idx      <= '0;
      csum     <= '0;
      pend_vld <= 1'b0;
      fault    <= 1'b0;
    end else begin
      if (st == SYNC && take && b == 8'hA5) begin
        csum     <= '0;
        idx      <= '0;
        bcnt     <= '0;
        boot_err <= 1'b0;
      end
      if (st == LEN0 && take) nlen[7:0] <= b;
      if (st == LEN1 && take) nlen[15:8] <= b;
      if (st == DATA && take) begin
        word <= {b, word[31:8]};
        csum <= csum ^ b;
        bcnt <= bcnt + 2'd1;
      end
      if (st == WAIT && bus.HREADY) idx <= idx + 16'd1;
      if (stall && fault_now) fault <= 1'b1;
      if (stall ? byte_vld : (pend_vld && byte_vld)) pend <= rx_sh;
      pend_vld <= stall ? (pend_vld || byte_vld) : (pend_vld && byte_vld) ? 1'b1 : take ? 1'b0 : pend_vld;
    end
  // bus and status outputs decoded from registered state
  always_comb begin
    bus.HTRANS = st == ADDR ? 2'b10 : 2'b00;
    bus.HADDR  = st == ADDR ? BASE_ADDR + {14'd0, idx, 2'b00} : 32'd0;
    bus.HWDATA = st == WAIT ? word : 32'd0;
    CPU_HOLD   = !done_q;
    BOOT_DONE  = done_q;
    BOOT_ERR   = boot_err;
  end
  assign bus.HWRITE    = 1'b1;
  assign bus.HSIZE     = 3'b010;
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = 4'b0011;
  assign bus.HMASTLOCK = 1'b0;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed and randomized image loads against a byte-stream reference model
module tb_uart_boot_loader;
  localparam int BD = 16;
  logic clk = 1'b0, rst_n = 1'b0, rxd = 1'b1;
  logic cpu_hold, boot_done, boot_err;
  uart_boot_loader_if bus();
  uart_boot_loader #(
    .BAUD_DIV(BD), .BASE_ADDR(32'h0), .MAX_WORDS(16384)
`ifdef UART_BOOT_TIMEOUT_EN
    , .TIMEOUT_CYC(1000)
`endif
  ) dut (
    .HCLK(clk), .HRESETn(rst_n), .RXD(rxd), .bus(bus),
    .CPU_HOLD(cpu_hold), .BOOT_DONE(boot_done), .BOOT_ERR(boot_err)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  logic [31:0] wa_q[$], wd_q[$], exp_w[$];
  logic [31:0] a_q, d0;
  int stall_mode = 0, err_at = -1, wr_num = 0, stall_left = 0, unstable = 0, overlap = 0;
  bit dphase = 0, first = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      dphase = 0; wr_num = 0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    end else begin
      if (dphase) begin
        if (first) begin d0 = bus.HWDATA; first = 0; end
        else if (bus.HWDATA !== d0) unstable++;
        if (stall_left > 0) begin
          bus.HREADY = 1'b0; bus.HRESP = 1'b0; stall_left--;
        end else begin
          bus.HREADY = 1'b1; bus.HRESP = wr_num == err_at;
          wa_q.push_back(a_q); wd_q.push_back(bus.HWDATA); wr_num++; dphase = 0;
        end
      end else begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      end
      if (bus.HTRANS == 2'b10) begin
        if (dphase) overlap++;
        dphase = 1; first = 1; a_q = bus.HADDR;
        stall_left = (stall_mode == 2 && wr_num == 0) ? 5 : stall_mode == 1 ? $urandom_range(0, 3) : 0;
      end else if (bus.HTRANS !== 2'b00) overlap++;
    end
  end
  task automatic send_byte(logic [7:0] v, bit bad = 0);
    rxd = 1'b0; repeat (BD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin rxd = v[i]; repeat (BD) @(posedge clk); end
    rxd = !bad; repeat (BD) @(posedge clk);
    if (bad) begin rxd = 1'b1; repeat (BD) @(posedge clk); end
  endtask
  logic [7:0] std_s[11] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  task automatic send_std(logic [7:0] cs, int from = 0);
    for (int i = from; i < 11; i++) send_byte(std_s[i]);
    send_byte(cs);
    repeat (4) @(negedge clk);
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0;
    wa_q.delete(); wd_q.delete();
    stall_mode = 0; err_at = -1; unstable = 0; overlap = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic check_writes(string tag, int nw);
    check({tag, ".nwr"}, 32'(wa_q.size()), 32'(nw));
    for (int i = 0; i < nw && i < wa_q.size(); i++) begin
      check($sformatf("%s.addr%0d", tag, i), wa_q[i], 32'(4 * i));
      check($sformatf("%s.data%0d", tag, i), wd_q[i], exp_w[i]);
    end
    check({tag, ".stable"}, 32'(unstable), 0);
    check({tag, ".single"}, 32'(overlap), 0);
  endtask
  task automatic check_status(string tag, bit done);
    check({tag, ".done"}, boot_done, done);
    check({tag, ".hold"}, cpu_hold, !done);
    check({tag, ".err"}, boot_err, !done);
  endtask
  task automatic run_rand(int t);
    int n, mode, eidx;
    logic [7:0] by[$];
    logic [7:0] cs, x;
    n = $urandom_range(0, 4);
    mode = $urandom_range(0, 2);
    if (mode == 2 && n == 0) mode = 1;
    eidx = n > 0 ? $urandom_range(0, n - 1) : 0;
    do begin
      by.delete(); cs = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        x = 8'($urandom_range(0, 255));
        if (x == 8'hA5) x = 8'h5A;
        by.push_back(x); cs ^= x;
      end
    end while (cs == 8'hA5 || cs == 8'hA4);
    exp_w.delete();
    for (int i = 0; i < n; i++)
      exp_w.push_back(32'(by[4*i]) + 32'(by[4*i+1]) * 256 + 32'(by[4*i+2]) * 65536 + 32'(by[4*i+3]) * 16777216);
    pulse_reset();
    stall_mode = 1;
    err_at = mode == 2 ? eidx : -1;
    for (int j = $urandom_range(0, 2); j > 0; j--) send_byte(8'($urandom_range(0, 164)));
    send_byte(8'hA5); send_byte(8'(n)); send_byte(8'h00);
    foreach (by[i]) send_byte(by[i]);
    send_byte(mode == 1 ? cs ^ 8'h01 : cs);
    repeat (4) @(negedge clk);
    check_writes($sformatf("rnd%0d", t), mode == 2 ? eidx + 1 : n);
    check_status($sformatf("rnd%0d", t), mode == 0);
  endtask
  initial begin
    bit found;
    int cyc;
    repeat (2) @(negedge clk);
    check("rst.hold", cpu_hold, 1);
    check("rst.done", boot_done, 0);
    check("rst.err", boot_err, 0);
    check("rst.htrans", bus.HTRANS, 0);
    check("rst.haddr", bus.HADDR, 0);
    check("rst.hwdata", bus.HWDATA, 0);
    exp_w = '{32'h12345678, 32'hDEADBEEF};
    pulse_reset();
    send_std(8'h2A);
    check_writes("good", 2);
    check_status("good", 1);
    pulse_reset();
    send_std(8'h2B);
    check_writes("badcs", 2);
    check_status("badcs", 0);
    wa_q.delete(); wd_q.delete();
    send_byte(8'hA5);
    repeat (4) @(negedge clk);
    check("retry.errclr", boot_err, 0);
    send_std(8'h2A, 1);
    check_writes("retry", 2);
    check_status("retry", 1);
    pulse_reset();
    stall_mode = 2;
    send_std(8'h2A);
    check_writes("stall", 2);
    check_status("stall", 1);
    pulse_reset();
    err_at = 1;
    send_std(8'h2A);
    check_writes("hresp", 2);
    check_status("hresp", 0);
    send_byte(8'h00); send_byte(8'hFF);
    repeat (4) @(negedge clk);
    check("hresp.ign_nwr", 32'(wa_q.size()), 2);
    check_status("hresp.ign", 0);
    pulse_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33, 1);
    repeat (4) @(negedge clk);
    check("frame.nwr", 32'(wa_q.size()), 0);
    check_status("frame", 0);
    pulse_reset();
    send_byte(8'hA5); send_byte(8'hFF); send_byte(8'hFF);
    repeat (4) @(negedge clk);
    check_status("len_ffff", 0);
    pulse_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h40);
    repeat (4) @(negedge clk);
    check("len_max.err", boot_err, 0);
    pulse_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h40);
    repeat (4) @(negedge clk);
    check("len_max1.err", boot_err, 1);
    pulse_reset();
    for (int i = 0; i < 6; i++) send_byte(std_s[i]);
    fork
      send_byte(8'h12);
      begin
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin @(negedge clk); found = bus.HTRANS == 2'b10; end
        check("arst.seen_addr", found, 1);
        #2 rst_n = 1'b0;
        #1 check("arst.htrans", bus.HTRANS, 0);
        check("arst.hold", cpu_hold, 1);
      end
    join
    wa_q.delete(); wd_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_std(8'h2A);
    check_writes("arst", 2);
    check_status("arst", 1);
`ifdef UART_BOOT_TIMEOUT_EN
    pulse_reset();
    send_byte(8'hA5); send_byte(8'h02);
    cyc = 0;
    while (!boot_err && cyc < 3000) begin @(negedge clk); cyc++; end
    check("tmo.err", boot_err, 1);
    check("tmo.cyc_lo", cyc >= 980, 1);
    check("tmo.cyc_hi", cyc <= 1010, 1);
`else
    cyc = 0;
`endif
    for (int t = 0; t < 10; t++) run_rand(t);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
